// File: rtl/vec_reg_bank_seq_pkg.sv
// Shared constants and state encoding for the operand register bank and its scan counter.
package vec_reg_bank_seq_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int SEL_W       = 4;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

endpackage

// File: rtl/vec_scan_ctr.sv
// Scan step counter: walks sel from 0 to count-1 on step_en and pulses done
// the cycle after the final step.
module vec_scan_ctr
  import vec_reg_bank_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_en,
  input  logic [CNT_W-1:0] count,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             last_step,
  output logic             done
);

  logic [SEL_W-1:0] sel_reg;
  logic             valid_reg;
  logic             done_reg;
  logic [CNT_W-1:0] last_idx;

  // Terminal compare is done at count width so sel can never run past the loaded range.
  assign last_idx  = count - 5'd1;
  assign last_step = valid_reg && step_en && ({1'b0, sel_reg} == last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= last_step;
      if (start) begin
        sel_reg   <= '0;
        valid_reg <= 1'b1;
      end else if (last_step) begin
        sel_reg   <= '0;
        valid_reg <= 1'b0;
      end else if (valid_reg && step_en) begin
        sel_reg <= sel_reg + 4'd1;
      end
    end
  end

  assign sel       = sel_reg;
  assign sel_valid = valid_reg;
  assign done      = done_reg;

endmodule

// File: rtl/vec_reg_bank_seq.sv
// 16-entry operand bank: serial fill over valid/ready, parallel presentation on
// regs_flat, and a stepped scan that drives the downstream 16:1 mux select.
module vec_reg_bank_seq
  import vec_reg_bank_seq_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  input  logic [SIZE-1:0]             load_data,
  input  logic                        load_last,
  output logic                        load_ready,
  input  logic                        reload,
  input  logic                        start,
  input  logic                        step_en,
  output logic [NUM_ENTRIES*SIZE-1:0] regs_flat,
  output logic [CNT_W-1:0]            count,
  output logic [SEL_W-1:0]            sel,
  output logic                        sel_valid,
  output logic                        done,
  output logic                        busy
);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [SIZE-1:0]  entry_reg [NUM_ENTRIES];
  logic             fire;
  logic             fill_end;
  logic             scan_start;
  logic             last_step;

  assign load_ready = (state_reg == ST_FILL);
  assign fire       = load_valid && load_ready;
  assign fill_end   = fire && (load_last || (wr_ptr_reg == SEL_W'(NUM_ENTRIES - 1)));
  // reload wins over a simultaneous start
  assign scan_start = (state_reg == ST_HOLD) && !reload && start;

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    case (state_reg)
      ST_FILL: begin
        if (fire) begin
          wr_ptr_next = wr_ptr_reg + 4'd1;
          if (fill_end) begin
            count_next  = {1'b0, wr_ptr_reg} + 5'd1;
            wr_ptr_next = '0;
            state_next  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (reload) begin
          count_next  = '0;
          wr_ptr_next = '0;
          state_next  = ST_FILL;
        end else if (start) begin
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (last_step) state_next = ST_HOLD;
      end
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_FILL;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entries are not cleared on reload; the next fill overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_reg[i] <= '0;
    end else if (fire) begin
      entry_reg[wr_ptr_reg] <= load_data;
    end
  end

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_flat
    assign regs_flat[gi*SIZE +: SIZE] = entry_reg[gi];
  end

  vec_scan_ctr u_scan_ctr (
    .clk       (clk),
    .rst       (rst),
    .start     (scan_start),
    .step_en   (step_en),
    .count     (count_reg),
    .sel       (sel),
    .sel_valid (sel_valid),
    .last_step (last_step),
    .done      (done)
  );

  assign count = count_reg;
  assign busy  = (state_reg == ST_SCAN);

endmodule

// File: tb/tb_vec_reg_bank_seq.sv
// Self-checking bench for vec_reg_bank_seq: load and scan scoreboards, priority
// cases and asynchronous reset in the middle of a scan.
module tb_vec_reg_bank_seq;

  localparam int SIZE = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_valid = 1'b0;
  logic [SIZE-1:0]   load_data = '0;
  logic              load_last = 1'b0;
  logic              reload = 1'b0;
  logic              start = 1'b0;
  logic              step_en = 1'b0;
  logic              load_ready;
  logic [16*SIZE-1:0] regs_flat;
  logic [4:0]        count;
  logic [3:0]        sel;
  logic              sel_valid;
  logic              done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              idx;
    logic [SIZE-1:0] data;
  } load_exp_t;

  load_exp_t  load_q[$];
  logic [3:0] sel_q[$];

  vec_reg_bank_seq #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .reload     (reload),
    .start      (start),
    .step_en    (step_en),
    .regs_flat  (regs_flat),
    .count      (count),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [SIZE-1:0] entry(input int k);
    return regs_flat[k*SIZE +: SIZE];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; if acceptance is expected, the entry it must land in is queued
  // and compared once the handshake edge has passed.
  task automatic send_word(input logic [SIZE-1:0] d, input logic last, input bit exp_acc, input int idx);
    load_exp_t e;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    check("load_ready", load_ready, exp_acc);
    if (exp_acc) begin
      e.idx  = idx;
      e.data = d;
      load_q.push_back(e);
    end
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    while (load_q.size() > 0) begin
      e = load_q.pop_front();
      check($sformatf("entry%0d", e.idx), entry(e.idx), e.data);
    end
  endtask

  initial begin
    bit pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // reset state
    #12;
    check("rst_load_ready", load_ready, 1);
    check("rst_count", count, 0);
    check("rst_sel", sel, 0);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_regs_zero", regs_flat == '0, 1);
    rst = 1'b0;
    tick();

    // short load terminated by load_last
    send_word(16'h0011, 1'b0, 1'b1, 0);
    send_word(16'h0022, 1'b0, 1'b1, 1);
    send_word(16'h0033, 1'b1, 1'b1, 2);
    check("short_count", count, 3);
    check("short_ready", load_ready, 0);
    check("short_busy", busy, 0);

    // load_valid in HOLD is refused
    send_word(16'hBEEF, 1'b0, 1'b0, 0);
    check("hold_entry0", entry(0), 16'h0011);
    check("hold_count", count, 3);

    // scan with stalls; reload/start during SCAN must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("scan_busy", busy, 1);
    sel_q.push_back(4'd0);
    sel_q.push_back(4'd1);
    sel_q.push_back(4'd1);
    sel_q.push_back(4'd1);
    sel_q.push_back(4'd2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("scan_sel%0d", i), sel, sel_q.pop_front());
      check("scan_sel_valid", sel_valid, 1);
      check("scan_no_done", done, 0);
      step_en = pat[i];
      reload  = (i == 1);
      start   = (i == 2);
      tick();
    end
    step_en = 1'b0;
    reload  = 1'b0;
    start   = 1'b0;
    check("scan_done", done, 1);
    check("scan_end_sel_valid", sel_valid, 0);
    check("scan_end_busy", busy, 0);
    check("scan_end_sel", sel, 0);
    check("scan_end_count", count, 3);
    check("scan_end_ready", load_ready, 0);
    tick();
    check("scan_done_pulse", done, 0);

    // reload beats start in HOLD
    reload = 1'b1;
    start  = 1'b1;
    tick();
    reload = 1'b0;
    start  = 1'b0;
    check("prio_count", count, 0);
    check("prio_ready", load_ready, 1);
    check("prio_busy", busy, 0);
    check("prio_sel_valid", sel_valid, 0);
    tick();
    check("prio_busy2", busy, 0);

    // single-entry scan
    send_word(16'h0055, 1'b1, 1'b1, 0);
    check("single_count", count, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("single_sel_valid", sel_valid, 1);
    check("single_sel", sel, 0);
    check("single_no_done", done, 0);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    check("single_done", done, 1);
    check("single_end_valid", sel_valid, 0);
    tick();
    check("single_done_pulse", done, 0);

    // full load: 16 words end FILL without load_last, 17th refused
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("full_ready_start", load_ready, 1);
    for (int i = 0; i < 16; i++) begin
      send_word(SIZE'(16'h1000 + i), 1'b0, 1'b1, i);
    end
    check("full_ready_end", load_ready, 0);
    check("full_count", count, 16);
    send_word(16'hDEAD, 1'b0, 1'b0, 0);
    check("full_entry15", entry(15), 16'h100F);
    check("full_entry0", entry(0), 16'h1000);
    check("full_count_after17", count, 16);

    // async reset while sel==2
    start = 1'b1;
    tick();
    start   = 1'b0;
    step_en = 1'b1;
    sel_q.push_back(4'd0);
    sel_q.push_back(4'd1);
    sel_q.push_back(4'd2);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rstscan_sel%0d", k), sel, sel_q.pop_front());
      tick();
    end
    check("rstscan_sel2", sel, sel_q.pop_front());
    step_en = 1'b0;
    rst     = 1'b1;
    #1;
    check("arst_sel", sel, 0);
    check("arst_sel_valid", sel_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_count", count, 0);
    check("arst_ready", load_ready, 1);
    check("arst_regs_zero", regs_flat == '0, 1);
    tick();
    check("arst_done_edge", done, 0);
    rst = 1'b0;
    tick();
    check("arst_done_after", done, 0);
    check("arst_ready_after", load_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_reg_bank_seq.md
Name: vec_reg_bank_seq

Overview:
- 16-entry operand register bank with serial load port and a scan sequencer, directly upstream of the 16:1 operand mux.
- Loads up to 16 SIZE-bit words (ODE coefficients/state values) over a valid/ready handshake.
- Presents all entries in parallel on a flattened bus wired to mux inputs in1..in16; drives the mux's 4-bit select through the loaded entries, one per step.

Parameters:
- SIZE, 16, word width of each entry; must match the downstream mux SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  load word present.
- load_data  in  SIZE  load word.
- load_last  in  1  qualifies the final word of a load burst.
- load_ready  out  1  bank accepts a word this cycle.
- reload  in  1  pulse: discard contents and begin a new load (honoured in HOLD only).
- start  in  1  pulse: begin a scan (honoured in HOLD only).
- step_en  in  1  advance the scan by one entry.
- regs_flat  out  16*SIZE  entry k at bits [k*SIZE +: SIZE]; entry 0 feeds in1, entry 15 feeds in16.
- count  out  5  number of valid entries, 0..16.
- sel  out  4  mux select; index of the current entry.
- sel_valid  out  1  sel addresses a valid entry under scan.
- done  out  1  one-cycle pulse after the last entry is stepped.
- busy  out  1  high in SCAN.

Behaviour:
- Reset (async, immediate):
  - State FILL; wr_ptr=0.
  - All entries, count, sel, sel_valid, done and busy are 0; load_ready=1.
- FILL state:
  - load_ready=1.
  - Handshake fires when load_valid&&load_ready; entry[wr_ptr] <= load_data; wr_ptr++.
  - On the fire cycle, if load_last=1 or wr_ptr==15: count <= wr_ptr+1, wr_ptr <= 0, next state HOLD.
  - load_last without load_valid has no effect. start and step_en are ignored.
- HOLD state:
  - load_ready=0; entries and count are stable.
  - If reload=1: count <= 0, wr_ptr <= 0, next state FILL. Entries are not cleared; they are overwritten by the next load.
  - Else if start=1: sel <= 0, sel_valid <= 1, busy <= 1, next state SCAN.
  - reload has priority over a simultaneous start.
- SCAN state:
  - load_ready=0; reload and start are ignored.
  - step_en=1 with sel < count-1: sel <= sel+1.
  - step_en=1 with sel == count-1: sel <= 0, sel_valid <= 0, busy <= 0, done <= 1 for exactly one cycle, next state HOLD.
  - step_en=0: sel holds. Stalls of any length are legal.
- Latency:
  - Entry value is visible on regs_flat the cycle after its handshake.
  - sel_valid rises the cycle after start.
  - With step_en held high, done is asserted count+1 cycles after start.
- Width rules:
  - sel never exceeds count-1, so there is no wrap-around beyond the loaded range.
  - count is 5 bits so that 16 is representable. count==16 ends FILL automatically; a 17th word is never accepted.
- sel outside SCAN is 0, so the downstream mux output is entry 0.
- Reset asserted mid-load or mid-scan returns to the reset state immediately. No done pulse is generated.

Decomposition:
- Shared package:
  - State encoding constants ST_FILL=2'd0, ST_HOLD=2'd1, ST_SCAN=2'd2.
  - Constant NUM_ENTRIES=16.
  - Constant SEL_W=4.
- One natural sub-module, vec_scan_ctr: a 4-bit step counter with terminal-count compare against count-1 that produces sel and the done pulse. The FSM and the register array stay in the top.

Test Plan:
- Reset and short load: reset, then load 3 words 0x0011, 0x0022, 0x0033 with load_last on the third -> count=3, entries 0..2 show those values, state HOLD, load_ready=0.
- Full load: 16 consecutive words 0x1000..0x100F with no load_last, then a 17th valid word -> count=16, load_ready drops after the 16th, the 17th is not accepted, entry 15 = 0x100F.
- Scan with stalls: count=3, start, step_en pattern 1,0,0,1,1 -> sel sequence 0,1,1,1,2, then a done pulse, sel_valid low, busy low, state HOLD.
- Single entry: count=1, start, step_en=1 -> sel=0 for one cycle, done the next cycle.
- Priority and ignores:
  - reload and start together in HOLD -> FILL, count=0, no scan.
  - start or reload during SCAN -> no effect.
  - load_valid during HOLD -> not accepted.
- Async reset mid-scan: assert rst while sel=2 -> all outputs 0 and load_ready=1 without waiting for a clock edge; no done pulse.
